// File: rtl/divu_unit.sv
// 32-bit restoring divider (quotient MSB first); `DIVU_SIGNED_EN adds signed divide on DIV_CODE.
// Latency 34 cycles start-to-done (1 for a zero divisor); starts seen while busy are dropped, no queueing.
module divu_unit #(
   parameter logic [5:0] DIVU_CODE = 6'b011011,
   parameter logic [5:0] DIV_CODE  = 6'b011010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  Signal,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic [31:0] HiOut,
   output logic [31:0] LoOut,
   output logic        busy,
   output logic        done,
   output logic        divZero
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dsr_q, dsr_d;
   logic        zero_q, zero_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dz_q, dz_d;

   logic        start_u;
   logic        go;
   logic [31:0] op_a, op_b;
   logic [33:0] rem_sh;
   logic [32:0] rem_sub;
   logic        step_ge;

   // An aliased DIV_CODE still reads as an unsigned start
   assign start_u = (Signal == DIVU_CODE) || ((DIV_CODE == DIVU_CODE) && (Signal == DIV_CODE));

`ifdef DIVU_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;
   logic start_s;

   assign start_s = (Signal == DIV_CODE) && !start_u;
   assign go      = start_u || start_s;
   assign op_a    = (start_s && dataA[31]) ? -dataA : dataA;
   assign op_b    = (start_s && dataB[31]) ? -dataB : dataB;
`else
   assign go      = start_u;
   assign op_a    = dataA;
   assign op_b    = dataB;
`endif

   assign rem_sh  = {rem_q, quo_q[31]};
   assign rem_sub = rem_sh[32:0] - {1'b0, dsr_q};
   assign step_ge = (rem_sh >= {2'b00, dsr_q});

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dsr_d   = dsr_q;
      zero_d  = zero_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
`ifdef DIVU_SIGNED_EN
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         IDLE: begin
            if (go) begin
               dz_d    = 1'b0;
               count_d = 5'd0;
               dsr_d   = op_b;
               zero_d  = (dataB == 32'd0);
`ifdef DIVU_SIGNED_EN
               neg_quo_d = start_s && (dataA[31] ^ dataB[31]);
               neg_rem_d = start_s && dataA[31];
`endif
               if (dataB == 32'd0) begin
                  quo_d   = 32'hFFFF_FFFF;
                  rem_d   = {1'b0, dataA};
                  state_d = DONE;
               end else begin
                  quo_d   = op_a;
                  rem_d   = 33'd0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            quo_d   = {quo_q[30:0], step_ge};
            rem_d   = step_ge ? rem_sub : rem_sh[32:0];
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d = FIX;
            end
         end
         FIX: begin
`ifdef DIVU_SIGNED_EN
            if (neg_quo_q) begin
               quo_d = -quo_q;
            end
            if (neg_rem_q) begin
               rem_d = {1'b0, -rem_q[31:0]};
            end
`endif
            state_d = DONE;
         end
         DONE: begin
            lo_d    = quo_q;
            hi_d    = rem_q[31:0];
            dz_d    = zero_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 5'd0;
         rem_q   <= 33'd0;
         quo_q   <= 32'd0;
         dsr_q   <= 32'd0;
         zero_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
`ifdef DIVU_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dsr_q   <= dsr_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
`ifdef DIVU_SIGNED_EN
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign HiOut   = hi_q;
   assign LoOut   = lo_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign divZero = dz_q;

endmodule

// File: tb/tb_divu_unit.sv
// Bench for divu_unit: vector table, hand-written corner sequences, random ops against a plain-arithmetic model.
module tb_divu_unit;

   localparam logic [5:0] DIVU = 6'b011011;
   localparam logic [5:0] DIV  = 6'b011010;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  Signal;
   logic [31:0] dataA, dataB;
   logic [31:0] HiOut, LoOut;
   logic        busy, done, divZero;

   divu_unit #(.DIVU_CODE(DIVU), .DIV_CODE(DIV)) dut (
      .clk(clk), .rst(rst), .Signal(Signal), .dataA(dataA), .dataB(dataB),
      .HiOut(HiOut), .LoOut(LoOut), .busy(busy), .done(done), .divZero(divZero)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [5:0]  code;
      logic [31:0] a, b, q, r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic [5:0] c, logic [31:0] a, logic [31:0] b,
                               logic [31:0] q, logic [31:0] r, logic dz, int lat);
      vec_t v;
      v.code = c; v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
      return v;
   endfunction

   // Reference: plain integer division, truncating toward zero for signed ops
   task automatic model(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
      longint sa, sb;
      dz = (b == 32'd0);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (code == DIV) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // Called right after a falling edge; returns at the falling edge where done is seen
   task automatic do_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
      Signal = code; dataA = a; dataB = b;
      @(posedge clk);
      @(negedge clk);
      Signal = 6'd0; dataA = $urandom; dataB = $urandom;
      lat  = 0;
      bcnt = busy ? 1 : 0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) break;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, bcnt, cnt, gap, dn;
      logic [31:0] q, r;
      logic dz;
      logic [5:0] code;
      logic [31:0] a, b;

      vecs.push_back(mk(DIVU, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34));
      vecs.push_back(mk(DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34));
      vecs.push_back(mk(DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1));
      vecs.push_back(mk(DIVU, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 34));
      vecs.push_back(mk(DIVU, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34));
      vecs.push_back(mk(DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 34));
      vecs.push_back(mk(DIVU, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0, 34));
      vecs.push_back(mk(DIVU, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 34));
`ifdef DIVU_SIGNED_EN
      vecs.push_back(mk(DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34));
      vecs.push_back(mk(DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34));
      vecs.push_back(mk(DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34));
      vecs.push_back(mk(DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1));
`endif

      rst = 1'b1; Signal = 6'd0; dataA = 32'd0; dataB = 32'd0;
      @(negedge clk);
      check("reset HiOut", HiOut, 32'd0);
      check("reset LoOut", LoOut, 32'd0);
      check1("reset busy", busy, 1'b0);
      check1("reset done", done, 1'b0);
      check1("reset divZero", divZero, 1'b0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         do_op(vecs[i].code, vecs[i].a, vecs[i].b, lat, bcnt);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].lat);
         check($sformatf("vec%0d LoOut", i), LoOut, vecs[i].q);
         check($sformatf("vec%0d HiOut", i), HiOut, vecs[i].r);
         check1($sformatf("vec%0d divZero", i), divZero, vecs[i].dz);
         @(negedge clk);
         check1($sformatf("vec%0d done width", i), done, 1'b0);
      end

      // Start code held: ignored while busy and in DONE, taken again only in IDLE
      Signal = DIVU; dataA = 32'd100; dataB = 32'd7;
      cnt = 0;
      while (!done && cnt < 100) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      check("held start first done", cnt, 35);
      gap = 0;
      do begin
         @(posedge clk);
         gap++;
         @(negedge clk);
      end while (!done && gap < 100);
      check("held start done spacing", gap, 35);
      Signal = 6'd0;
      check("held start LoOut", LoOut, 32'd14);
      check("held start HiOut", HiOut, 32'd2);

`ifndef DIVU_SIGNED_EN
      Signal = DIV; dataA = 32'h8000_0000; dataB = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      Signal = 6'd0;
      check1("DIV_CODE ignored busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      check1("DIV_CODE ignored busy later", busy, 1'b0);
      check("DIV_CODE LoOut held", LoOut, 32'd14);
      check("DIV_CODE HiOut held", HiOut, 32'd2);
`else
      repeat (3) @(negedge clk);
      check("idle LoOut held", LoOut, 32'd14);
      check("idle HiOut held", HiOut, 32'd2);
`endif

      for (int k = 0; k < 40; k++) begin
         int sel;
`ifdef DIVU_SIGNED_EN
         code = ($urandom_range(0, 1) == 1) ? DIV : DIVU;
`else
         code = DIVU;
`endif
         a   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)      b = 32'd0;
         else if (sel < 4)  b = $urandom_range(1, 300);
         else if (sel == 4) b = 32'hFFFF_FFFF - $urandom_range(0, 5);
         else               b = $urandom;
         model(code, a, b, q, r, dz);
         do_op(code, a, b, lat, bcnt);
         check($sformatf("rand%0d latency", k), lat, (b == 32'd0) ? 1 : 34);
         check($sformatf("rand%0d LoOut", k), LoOut, q);
         check($sformatf("rand%0d HiOut", k), HiOut, r);
         check1($sformatf("rand%0d divZero", k), divZero, dz);
      end

      // Mid-operation reset with an ignored second start
      Signal = DIVU; dataA = 32'd50; dataB = 32'd5;
      @(posedge clk);
      @(negedge clk);
      Signal = 6'd0;
      dn = 0;
      for (int c = 1; c < 20; c++) begin
         if (c == 10) begin
            Signal = DIVU; dataA = 32'd9; dataB = 32'd3;
         end else begin
            Signal = 6'd0;
         end
         @(posedge clk);
         @(negedge clk);
         if (done) dn++;
      end
      Signal = 6'd0;
      check1("pre-reset busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("abort HiOut", HiOut, 32'd0);
      check("abort LoOut", LoOut, 32'd0);
      check1("abort busy", busy, 1'b0);
      check1("abort divZero", divZero, 1'b0);
      for (int c = 0; c < 40; c++) begin
         if (c == 2) rst = 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (done) dn++;
      end
      check("abort done pulses", dn, 0);
      check("abort LoOut stays", LoOut, 32'd0);
      check("abort HiOut stays", HiOut, 32'd0);

      // Start on the very first edge after reset release
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do_op(DIVU, 32'd100, 32'd7, lat, bcnt);
      check("post-reset latency", lat, 34);
      check("post-reset LoOut", LoOut, 32'd14);
      check("post-reset HiOut", HiOut, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/divu_unit.md
DIVU_UNIT -- requirements
Module: divu_unit

Interface
REQ-001 SHALL have parameter DIVU_CODE, default 6'b011011 (d27), the funct code that starts an unsigned divide.
REQ-002 SHALL have parameter DIV_CODE, default 6'b011010 (d26), the funct code that starts a signed divide (used only with DIVU_SIGNED_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Signal, input, 6 bits: funct code, sampled every cycle.
REQ-006 SHALL have port dataA, input, 32 bits: dividend.
REQ-007 SHALL have port dataB, input, 32 bits: divisor.
REQ-008 SHALL have port HiOut, output, 32 bits: remainder register.
REQ-009 SHALL have port LoOut, output, 32 bits: quotient register.
REQ-010 SHALL have port busy, output, 1 bit: high while a divide is in progress.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse when HiOut/LoOut are updated.
REQ-012 SHALL have port divZero, output, 1 bit: set with done when the divisor was zero; held until the next start.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE; encoding is free.
REQ-014 IDLE: Signal==DIVU_CODE SHALL latch dataA and dataB, clear divZero, and go to RUN with iteration count 0 (or DONE if dataB==0).
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle, producing quotient bits MSB first, over exactly 32 cycles (count 0..31).
REQ-016 After count 31, RUN SHALL go to FIX; FIX SHALL apply sign correction (signed mode only; otherwise pass-through) and then go to DONE.
REQ-017 DONE SHALL load LoOut=quotient and HiOut=remainder, pulse done for one cycle, and return to IDLE.
REQ-018 Latency: start edge to done high is 34 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-019 busy SHALL be high in RUN, FIX and DONE, and low in IDLE.
REQ-020 Signal matching a start code while busy SHALL be ignored; no queuing.
REQ-021 A zero divisor SHALL give LoOut=32'hFFFFFFFF, HiOut=dividend, and divZero=1.
REQ-022 HiOut and LoOut SHALL hold their last values between operations; operand changes after the start edge SHALL have no effect.
REQ-023 Internal partial remainder SHALL be 33 bits wide; the quotient/remainder satisfies dividend == q*divisor + r with r < divisor, unsigned.
REQ-024 A start code in the same cycle that DONE returns to IDLE SHALL not be accepted; acceptance requires the FSM to be in IDLE at that edge.

Reset
REQ-025 rst high SHALL immediately force IDLE and set HiOut=0, LoOut=0, busy=0, done=0, divZero=0 and the internal count to 0.
REQ-026 rst asserted mid-operation SHALL abort the divide with no done pulse, and results SHALL remain 0.
REQ-027 After rst deasserts, a start SHALL be accepted on the first rising edge.

Configuration
REQ-028 Macro DIVU_SIGNED_EN defined: Signal==DIV_CODE SHALL start a signed divide using magnitudes.
REQ-029 In signed mode, FIX SHALL negate the quotient if the operand signs differ, and negate the remainder if the dividend is negative.
REQ-030 In signed mode, 32'h80000000 / 32'hFFFFFFFF SHALL give LoOut=32'h80000000, HiOut=0, and divZero=0.
REQ-031 In signed mode, a zero divisor SHALL behave per REQ-021.
REQ-032 Macro not defined: DIV_CODE SHALL be ignored like any other non-start code, and no signed logic SHALL be synthesized.

Verification
REQ-033 100 / 7 via DIVU_CODE -> done exactly 34 cycles after start; LoOut=14, HiOut=2, divZero=0.
REQ-034 32'hFFFFFFFF / 1 -> LoOut=32'hFFFFFFFF, HiOut=0; busy high for 34 cycles.
REQ-035 dataB=0, dataA=32'h12345678 -> done 1 cycle after start; LoOut=32'hFFFFFFFF, HiOut=32'h12345678, divZero=1.
REQ-036 Start 50/5, issue a second start (9/3) at cycle 10, then pulse rst at cycle 20 -> second start ignored; after rst, all outputs 0 and no done pulse.
REQ-037 With DIVU_SIGNED_EN: -7 / 2 via DIV_CODE -> LoOut=32'hFFFFFFFD (-3), HiOut=32'hFFFFFFFF (-1).
REQ-038 With DIVU_SIGNED_EN: 32'h80000000 / 32'hFFFFFFFF -> LoOut=32'h80000000, HiOut=0; without the macro, the same DIV_CODE leaves busy=0 and outputs unchanged.
